mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single memory_unit port among N_REQ opcode/traversal

---
 rtl/mem_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter that shares the single memory_unit port among N_REQ
//   requester blocks (mem_traversal, cell_block, incr, equal). A rising edge on
//   req_execute[p] latches that port's address/function/write data into its own
//   holding registers. The arbiter then issues the request to memory_unit with a
//   one-cycle mem_execute strobe. When memory_unit answers, it returns a
//   one-cycle req_ready[p] pulse and the read data to that port only.
//
// Configuration
//   MEM_ARB_TIMEOUT_EN  when defined, a watchdog in WAIT completes the
//                       transaction with zero read data after TMO_CYC cycles
//                       and sets err_timeout. When undefined, WAIT waits
//                       indefinitely and err_timeout is tied to 0.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   req_execute[p]        request strobe per port (rising edge = new request)
//   req_address1/2        per-port addresses, port p at [p*ADDR_W +: ADDR_W]
//   req_func              per-port 2-bit memory function code
//   req_write_data        per-port write data
//   req_ready[p]          one-cycle completion pulse to the owning port
//   req_read_data1/2      completion data, valid while req_ready[p]=1
//   mem_*                 single shared interface to memory_unit
//   busy                  high while a transaction is in ISSUE/WAIT/DONE
//   grant_id              port currently owning memory
//   err_overrun[p]        sticky: new edge on p while p already pending
//   err_timeout           sticky: watchdog fired

`timescale 1ns/1ps

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 8
`endif

module mem_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W  = `MEMORY_DATA_WIDTH,
  parameter int TMO_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_execute,
  input  logic [N_REQ*ADDR_W-1:0]   req_address1,
  input  logic [N_REQ*ADDR_W-1:0]   req_address2,
  input  logic [N_REQ*2-1:0]        req_func,
  input  logic [N_REQ*DATA_W-1:0]   req_write_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         req_read_data1,
  output logic [DATA_W-1:0]         req_read_data2,
  output logic                      mem_execute,
  output logic [ADDR_W-1:0]         mem_address1,
  output logic [ADDR_W-1:0]         mem_address2,
  output logic [1:0]                mem_func,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_read_data1,
  input  logic [DATA_W-1:0]         mem_read_data2,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic [N_REQ-1:0]          err_overrun,
  output logic                      err_timeout
);

  localparam int SEL_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("mem_arbiter: N_REQ must be in 2..8");
  end
  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo_cyc
    $error("mem_arbiter: TMO_CYC must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                    state;
  logic [N_REQ-1:0]          exec_q;
  logic [N_REQ-1:0]          exec_edge;
  logic [N_REQ-1:0]          pending;
  logic [2:0]                last_grant;
  logic [N_REQ*ADDR_W-1:0]   hold_addr1;
  logic [N_REQ*ADDR_W-1:0]   hold_addr2;
  logic [N_REQ*2-1:0]        hold_func;
  logic [N_REQ*DATA_W-1:0]   hold_wdata;
  logic [SEL_W-1:0]          grant_sel;
  logic [N_REQ-1:0]          grant_onehot;
  logic                      next_found;
  logic [2:0]                next_port;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] tmo_cnt;
`endif

  assign exec_edge = req_execute & ~exec_q;
  assign grant_sel = grant_id[SEL_W-1:0];

  always_comb begin
    grant_onehot            = '0;
    grant_onehot[grant_sel] = 1'b1;
  end

  // Round-robin search starting just after last_grant. The loop runs from the
  // farthest candidate back to the nearest one so that the nearest pending port
  // overwrites the others and wins.
  always_comb begin
    next_found = 1'b0;
    next_port  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (pending[SEL_W'((int'(last_grant) + i) % N_REQ)]) begin
        next_found = 1'b1;
        next_port  = 3'((int'(last_grant) + i) % N_REQ);
      end
    end
  end

  // Request capture and the arbitration FSM share one register process.
  // A capture only sets a pending bit that is currently clear. Completion only
  // clears a pending bit that is currently set. The two can therefore never
  // target the same bit on the same edge. IDLE arbitrates on the registered
  // pending vector, so a request captured on this edge is considered next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      exec_q         <= '0;
      pending        <= '0;
      last_grant     <= 3'(N_REQ - 1);
      hold_addr1     <= '0;
      hold_addr2     <= '0;
      hold_func      <= '0;
      hold_wdata     <= '0;
      req_ready      <= '0;
      req_read_data1 <= '0;
      req_read_data2 <= '0;
      mem_execute    <= 1'b0;
      mem_address1   <= '0;
      mem_address2   <= '0;
      mem_func       <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
      grant_id       <= '0;
      err_overrun    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_timeout    <= 1'b0;
      tmo_cnt        <= '0;
`endif
    end else begin
      exec_q <= req_execute;

      for (int p = 0; p < N_REQ; p++) begin
        if (exec_edge[p]) begin
          if (pending[p]) begin
            err_overrun[p] <= 1'b1;
          end else begin
            pending[p]                          <= 1'b1;
            hold_addr1[p*ADDR_W +: ADDR_W]      <= req_address1[p*ADDR_W +: ADDR_W];
            hold_addr2[p*ADDR_W +: ADDR_W]      <= req_address2[p*ADDR_W +: ADDR_W];
            hold_func[p*2 +: 2]                 <= req_func[p*2 +: 2];
            hold_wdata[p*DATA_W +: DATA_W]      <= req_write_data[p*DATA_W +: DATA_W];
          end
        end
      end

      case (state)
        IDLE: begin
          if (next_found) begin
            mem_address1   <= hold_addr1[int'(next_port)*ADDR_W +: ADDR_W];
            mem_address2   <= hold_addr2[int'(next_port)*ADDR_W +: ADDR_W];
            mem_func       <= hold_func[int'(next_port)*2 +: 2];
            mem_write_data <= hold_wdata[int'(next_port)*DATA_W +: DATA_W];
            mem_execute    <= 1'b1;
            grant_id       <= next_port;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          mem_execute <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_cnt     <= '0;
`endif
          state       <= WAIT;
        end

        WAIT: begin
          if (mem_ready) begin
            req_read_data1     <= mem_read_data1;
            req_read_data2     <= mem_read_data2;
            req_ready          <= grant_onehot;
            pending[grant_sel] <= 1'b0;
            last_grant         <= grant_id;
            state              <= DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err_timeout        <= 1'b1;
            req_read_data1     <= '0;
            req_read_data2     <= '0;
            req_ready          <= grant_onehot;
            pending[grant_sel] <= 1'b0;
            last_grant         <= grant_id;
            state              <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end

        DONE: begin
          req_ready <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_ARB_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with N_REQ=4, 16-bit addresses, 8-bit data
//   and TMO_CYC=8. A small memory_unit model answers each mem_execute pulse.
//   It raises mem_ready on the second clock after the strobe. The read data is
//   derived from the issued address: rdata1 = addr1[7:0] ^ rdata_xor and
//   rdata2 = ~rdata1. The timeout scenario depends on MEM_ARB_TIMEOUT_EN being
//   defined for the build.

`timescale 1ns/1ps

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_execute;
  logic [63:0] req_address1;
  logic [63:0] req_address2;
  logic [7:0]  req_func;
  logic [31:0] req_write_data;
  logic [3:0]  req_ready;
  logic [7:0]  req_read_data1;
  logic [7:0]  req_read_data2;
  logic        mem_execute;
  logic [15:0] mem_address1;
  logic [15:0] mem_address2;
  logic [1:0]  mem_func;
  logic [7:0]  mem_write_data;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_read_data1;
  logic [7:0]  mem_read_data2;
  logic        busy;
  logic [2:0]  grant_id;
  logic [3:0]  err_overrun;
  logic        err_timeout;

  logic        model_en;
  logic [7:0]  rdata_xor;
  int          n_ops = 0;
  logic [15:0] last_op_addr1 = '0;
  logic [1:0]  last_op_func  = '0;
  logic [7:0]  last_op_wdata = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_arbiter #(
    .N_REQ(4), .ADDR_W(16), .DATA_W(8), .TMO_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_execute(req_execute), .req_address1(req_address1),
    .req_address2(req_address2), .req_func(req_func),
    .req_write_data(req_write_data), .req_ready(req_ready),
    .req_read_data1(req_read_data1), .req_read_data2(req_read_data2),
    .mem_execute(mem_execute), .mem_address1(mem_address1),
    .mem_address2(mem_address2), .mem_func(mem_func),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready),
    .mem_read_data1(mem_read_data1), .mem_read_data2(mem_read_data2),
    .busy(busy), .grant_id(grant_id), .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  assign mem_read_data1 = mem_address1[7:0] ^ rdata_xor;
  assign mem_read_data2 = ~mem_read_data1;

  // memory_unit stand-in: sees the strobe at the falling edge, then raises
  // mem_ready for one cycle starting just after the second following rising edge.
  always begin
    @(negedge clk);
    if (mem_execute && model_en) begin
      @(posedge clk);
      @(posedge clk);
      #1 mem_ready = 1'b1;
      @(posedge clk);
      #1 mem_ready = 1'b0;
    end
  end

  // Records every issued memory operation.
  always @(negedge clk) begin
    if (mem_execute) begin
      n_ops         <= n_ops + 1;
      last_op_addr1 <= mem_address1;
      last_op_func  <= mem_func;
      last_op_wdata <= mem_write_data;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses req_execute for the ports in the mask for one clock. Port p gets
  // addr1 = base + 16*p, addr2 = addr1 + 0x100, wdata = wd + p.
  task automatic applyStimulus(input logic [3:0] ports, input logic [15:0] base,
                               input logic [1:0] func, input logic [7:0] wd);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      if (ports[p]) begin
        req_address1[p*16 +: 16] = base + 16'(p * 16);
        req_address2[p*16 +: 16] = base + 16'h0100 + 16'(p * 16);
        req_func[p*2 +: 2]       = func;
        req_write_data[p*8 +: 8] = wd + 8'(p);
      end
    end
    req_execute = req_execute | ports;
    @(negedge clk);
    req_execute = req_execute & ~ports;
  endtask

  task automatic waitReady(input int bound, output logic [3:0] vec,
                           output logic [7:0] rd1, output logic [7:0] rd2,
                           output int cycles);
    vec    = '0;
    rd1    = '0;
    rd2    = '0;
    cycles = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      cycles++;
      if (|req_ready) begin
        vec = req_ready;
        rd1 = req_read_data1;
        rd2 = req_read_data2;
        break;
      end
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [3:0] vec;
  logic [7:0] rd1, rd2;
  int         cyc, ops0, seen;
  logic [3:0] exp_order [4];

  initial begin
    rst            = 1'b0;
    req_execute    = '0;
    req_address1   = '0;
    req_address2   = '0;
    req_func       = '0;
    req_write_data = '0;
    model_en       = 1'b1;
    rdata_xor      = 8'hBB;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_execute", 32'(mem_execute), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst_err_overrun", 32'(err_overrun), 32'h0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'h0);
    checkOutput("rst_mem_address1", 32'(mem_address1), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single request on port 1, addr1 0x10, func 01, wdata 0x41
    ops0 = n_ops;
    applyStimulus(4'b0010, 16'h0000, 2'b01, 8'h40);
    checkOutput("t1_no_early_exec", 32'(mem_execute), 32'h0);
    @(negedge clk);
    checkOutput("t1_mem_execute", 32'(mem_execute), 32'h1);
    checkOutput("t1_mem_address1", 32'(mem_address1), 32'h0010);
    checkOutput("t1_mem_address2", 32'(mem_address2), 32'h0110);
    checkOutput("t1_mem_func", 32'(mem_func), 32'h1);
    checkOutput("t1_mem_wdata", 32'(mem_write_data), 32'h41);
    checkOutput("t1_grant_id", 32'(grant_id), 32'h1);
    checkOutput("t1_busy", 32'(busy), 32'h1);
    waitReady(100, vec, rd1, rd2, cyc);
    checkOutput("t1_req_ready", 32'(vec), 32'h2);
    checkOutput("t1_rdata1", 32'(rd1), 32'hAB);
    checkOutput("t1_rdata2", 32'(rd2), 32'h54);
    checkOutput("t1_latency", 32'(cyc), 32'd3);
    @(negedge clk);
    checkOutput("t1_ready_one_cycle", 32'(req_ready), 32'h0);
    checkOutput("t1_ops", 32'(n_ops - ops0), 32'd1);

    // 2: ports 0,2,3 at once after reset (last_grant=3) -> order 0,2,3
    pulseReset();
    ops0 = n_ops;
    applyStimulus(4'b1101, 16'h0100, 2'b10, 8'h10);
    waitReady(100, vec, rd1, rd2, cyc);
    checkOutput("t2_grant0", 32'(vec), 32'h1);
    checkOutput("t2_rdata0", 32'(rd1), 32'hBB);
    waitReady(100, vec, rd1, rd2, cyc);
    checkOutput("t2_grant1", 32'(vec), 32'h4);
    checkOutput("t2_rdata1", 32'(rd1), 32'h9B);
    waitReady(100, vec, rd1, rd2, cyc);
    checkOutput("t2_grant2", 32'(vec), 32'h8);
    checkOutput("t2_rdata2", 32'(rd1), 32'h8B);
    checkOutput("t2_ops", 32'(n_ops - ops0), 32'd3);

    // 3: second edge on port 2 while pending -> overrun, dropped request
    ops0 = n_ops;
    checkOutput("t3_overrun_before", 32'(err_overrun), 32'h0);
    applyStimulus(4'b0100, 16'h0200, 2'b11, 8'h20);
    applyStimulus(4'b0100, 16'h0300, 2'b00, 8'h30);
    checkOutput("t3_err_overrun", 32'(err_overrun), 32'h4);
    waitReady(100, vec, rd1, rd2, cyc);
    checkOutput("t3_ready", 32'(vec), 32'h4);
    checkOutput("t3_rdata1", 32'(rd1), 32'h9B);
    checkOutput("t3_op_addr", 32'(last_op_addr1), 32'h0220);
    checkOutput("t3_op_func", 32'(last_op_func), 32'h3);
    checkOutput("t3_op_wdata", 32'(last_op_wdata), 32'h22);
    repeat (10) @(negedge clk);
    checkOutput("t3_ops", 32'(n_ops - ops0), 32'd1);
    checkOutput("t3_addr_hold", 32'(mem_address1), 32'h0220);
    checkOutput("t3_overrun_sticky", 32'(err_overrun), 32'h4);

    // 4: ports 0 and 1 re-request on their ready pulses -> 0,1,0,1
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0001;
    exp_order[3] = 4'b0010;
    applyStimulus(4'b0011, 16'h0400, 2'b01, 8'h50);
    for (int i = 0; i < 4; i++) begin
      waitReady(100, vec, rd1, rd2, cyc);
      checkOutput($sformatf("t4_grant%0d", i), 32'(vec), 32'(exp_order[i]));
      if (i < 2) begin
        req_execute = req_execute | vec;
        @(negedge clk);
        req_execute = req_execute & ~vec;
      end
    end

    // 5: reset during WAIT for port 3
    model_en = 1'b0;
    applyStimulus(4'b1000, 16'h0000, 2'b01, 8'h60);
    repeat (3) @(negedge clk);
    checkOutput("t5_busy_pre", 32'(busy), 32'h1);
    checkOutput("t5_grant_pre", 32'(grant_id), 32'h3);
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_mem_execute", 32'(mem_execute), 32'h0);
    checkOutput("t5_rst_busy", 32'(busy), 32'h0);
    checkOutput("t5_rst_grant", 32'(grant_id), 32'h0);
    checkOutput("t5_rst_overrun", 32'(err_overrun), 32'h0);
    checkOutput("t5_rst_addr", 32'(mem_address1), 32'h0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (|req_ready || mem_execute) seen++;
    end
    checkOutput("t5_no_activity", 32'(seen), 32'd0);
    checkOutput("t5_idle_busy", 32'(busy), 32'h0);
    model_en = 1'b1;
    applyStimulus(4'b1000, 16'h0400, 2'b10, 8'h70);
    waitReady(100, vec, rd1, rd2, cyc);
    checkOutput("t5_after_ready", 32'(vec), 32'h8);
    checkOutput("t5_after_rdata", 32'(rd1), 32'h8B);

    // 6: memory never answers
    model_en = 1'b0;
    applyStimulus(4'b0001, 16'h0500, 2'b01, 8'h80);
    @(negedge clk);
    checkOutput("t6_mem_execute", 32'(mem_execute), 32'h1);
`ifdef MEM_ARB_TIMEOUT_EN
    waitReady(100, vec, rd1, rd2, cyc);
    checkOutput("t6_tmo_ready", 32'(vec), 32'h1);
    checkOutput("t6_tmo_rdata1", 32'(rd1), 32'h0);
    checkOutput("t6_tmo_rdata2", 32'(rd2), 32'h0);
    checkOutput("t6_tmo_latency", 32'(cyc), 32'd9);
    checkOutput("t6_err_timeout", 32'(err_timeout), 32'h1);
`else
    waitReady(300, vec, rd1, rd2, cyc);
    checkOutput("t6_no_ready", 32'(vec), 32'h0);
    checkOutput("t6_still_busy", 32'(busy), 32'h1);
    checkOutput("t6_err_timeout", 32'(err_timeout), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
